// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity mode
// constants and the parity check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // data_xor is the XOR of all data bits; odd mode wants an odd total of ones
  function automatic logic parity_ok(input logic data_xor, input logic par_bit,
                                     input logic [1:0] mode);
    logic ok;
    case (mode)
      PAR_ODD:  ok = data_xor ^ par_bit;
      PAR_EVEN: ok = ~(data_xor ^ par_bit);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit timer plus three-point majority sampler. The timer runs 0..CLK_DIV-1
// and the decision strobe fires one count after mid-bit.
module uart_bit_sampler #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic rxs,
  output logic bit_val,
  output logic bit_strobe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(CLK_DIV / 2 + 1);

  logic [CW-1:0] cnt_r;
  logic          samp0_r;
  logic          samp1_r;

  // Bit timer, held at zero while the receiver is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // First two mid-bit samples; the third is the live rxs at the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp0_r <= 1'b1;
      samp1_r <= 1'b1;
    end else begin
      if (cnt_r == CNT_S0) samp0_r <= rxs;
      if (cnt_r == CNT_S1) samp1_r <= rxs;
    end
  end

  assign bit_strobe = (cnt_r == CNT_S2);
  assign bit_val    = (samp0_r & samp1_r) | (samp0_r & rxs) | (samp1_r & rxs);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: synchronises uart_rxd, decodes start/data/parity/stop
// bits and hands complete words to a valid/ready consumer with error pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [1:0] PAR_MODE  = 2'(PARITY);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0] CNT_ONE   = 4'd1;

  if (CLK_DIV < 8) begin : g_bad_clk_div
    $error("uart_rx_core: CLK_DIV must be 8 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5 to 9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end

  logic                 sync1_r;
  logic                 rxs_r;
  logic                 rxs_prev_r;
  rx_state_e            state_r;
  rx_state_e            state_next_s;
  logic                 bit_val_s;
  logic                 bit_strobe_s;
  logic                 clr_s;
  logic                 start_det_s;
  logic                 stop_bad_s;
  logic                 stop_done_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [3:0]           bit_cnt_r;
  logic                 any_one_r;
  logic                 par_ok_r;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      sync1_r    <= uart_rxd;
      rxs_r      <= sync1_r;
      rxs_prev_r <= rxs_r;
    end
  end

  assign start_det_s = (state_r == ST_IDLE) & rxs_prev_r & ~rxs_r;
  assign stop_bad_s  = (state_r == ST_STOP) & bit_strobe_s & ~bit_val_s;
  assign stop_done_s = (state_r == ST_STOP) & bit_strobe_s & bit_val_s & (bit_cnt_r == STOP_LAST);
  // Clearing on the way into IDLE keeps the timer at zero on the start cycle
  assign clr_s       = (state_next_s == ST_IDLE);

  uart_bit_sampler #(
    .CLK_DIV(CLK_DIV)
  ) u_sampler (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (clr_s),
    .rxs       (rxs_r),
    .bit_val   (bit_val_s),
    .bit_strobe(bit_strobe_s)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_next_s;
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_det_s) state_next_s = ST_START;
        else             state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_strobe_s) state_next_s = bit_val_s ? ST_IDLE : ST_DATA;
        else              state_next_s = ST_START;
      end
      ST_DATA: begin
        if (bit_strobe_s && bit_cnt_r == DATA_LAST)
          state_next_s = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PAR;
        else
          state_next_s = ST_DATA;
      end
      ST_PAR: begin
        if (bit_strobe_s) state_next_s = ST_STOP;
        else              state_next_s = ST_PAR;
      end
      ST_STOP: begin
        if (stop_bad_s)       state_next_s = ST_WAIT_HIGH;
        else if (stop_done_s) state_next_s = ST_IDLE;
        else                  state_next_s = ST_STOP;
      end
      ST_WAIT_HIGH: begin
        if (rxs_r) state_next_s = ST_IDLE;
        else       state_next_s = ST_WAIT_HIGH;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Frame datapath: shift register, bit counter, break and parity tracking
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_r   <= '0;
      bit_cnt_r <= 4'd0;
      any_one_r <= 1'b0;
      par_ok_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= 4'd0;
          any_one_r <= 1'b0;
          par_ok_r  <= 1'b1;
        end
        ST_DATA: begin
          if (bit_strobe_s) begin
            shift_r   <= {bit_val_s, shift_r[DATA_BITS-1:1]};
            any_one_r <= any_one_r | bit_val_s;
            bit_cnt_r <= (bit_cnt_r == DATA_LAST) ? 4'd0 : bit_cnt_r + CNT_ONE;
          end
        end
        ST_PAR: begin
          if (bit_strobe_s) begin
            par_ok_r  <= parity_ok(^shift_r, bit_val_s, PAR_MODE);
            any_one_r <= any_one_r | bit_val_s;
          end
        end
        ST_STOP: begin
          if (bit_strobe_s) begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
            any_one_r <= any_one_r | bit_val_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: word handoff, one-cycle error pulses and busy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= (state_next_s != ST_IDLE);
      if (stop_bad_s) begin
        break_det <= ~any_one_r;
        frame_err <= any_one_r;
      end
      if (stop_done_s && !par_ok_r) parity_err <= 1'b1;
      // A word consumed in the same cycle frees the slot for the new one
      if (stop_done_s && par_ok_r) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model checked every cycle on
// an 8N1 instance, plus literal timing checks and an 8E1 instance.
module tb_uart_rx_core;

  localparam int CLK_DIV = 16;
  localparam int EV_GOOD = 0;
  localparam int EV_PAR  = 1;
  localparam int EV_FRM  = 2;
  localparam int EV_BRK  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_e = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rdy_e = 1'b1;
  logic [7:0] rx_data, rx_data_e;
  logic       rx_valid, parity_err, frame_err, break_det, overrun, busy;
  logic       rx_valid_e, parity_err_e, frame_err_e, break_det_e, overrun_e, busy_e;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // model state: expected outputs for the current cycle
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_par = 1'b0, m_frm = 1'b0, m_brk = 1'b0;
  logic [7:0] m_data = 8'd0;
  int         ev_cyc = -1, ev_kind = 0, busy_lo = -1, busy_hi = -1;
  logic [7:0] ev_data = 8'd0;
  logic       ready_rand = 1'b0;
  int         n_ovr = 0, n_brk = 0, n_frm = 0, n_valid_e = 0, n_par_e = 0, n_other_e = 0;

  uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .CLK(clk), .RST(rst_n), .uart_rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .overrun(overrun), .busy(busy)
  );

  uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .CLK(clk), .RST(rst_n), .uart_rxd(rxd_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_ready(rdy_e), .parity_err(parity_err_e), .frame_err(frame_err_e),
    .break_det(break_det_e), .overrun(overrun_e), .busy(busy_e)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int x);
    forever begin
      @(negedge clk);
      if (cyc >= x) break;
    end
  endtask

  function automatic logic [19:0] mk(input logic [7:0] d, input logic stop);
    return {10'd0, stop, d, 1'b0};
  endfunction

  // Send an 8N1 bit sequence (LSB = start) and schedule what the receiver must do
  task automatic send(input logic [19:0] bits, input int nb);
    int n;
    int t0;
    int h;
    logic [7:0] d;
    n  = cyc;
    t0 = n + 2;
    d  = bits[8:1];
    ev_data = d;
    ev_cyc  = t0 + 9 * CLK_DIV + CLK_DIV / 2 + 2;
    busy_lo = t0 + 1;
    if (bits[9]) begin
      ev_kind = EV_GOOD;
      busy_hi = ev_cyc;
    end else begin
      ev_kind = (d != 8'd0) ? EV_FRM : EV_BRK;
      h = nb;
      for (int j = 10; j < nb; j++) if (bits[j] && h == nb) h = j;
      busy_hi = n + CLK_DIV * h + 3;
    end
    for (int i = 0; i < nb; i++) begin
      rxd = bits[i];
      repeat (CLK_DIV) step();
    end
    rxd = 1'b1;
  endtask

  task automatic send_e(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      rxd_e = bits[i];
      repeat (CLK_DIV) step();
    end
    rxd_e = 1'b1;
  endtask

  initial forever begin
    step();
    if (ready_rand) rx_ready = 1'($urandom_range(0, 1));
  end

  // Every-cycle compare against the frame-level model, then advance the model
  initial begin
    logic e_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_data = 8'd0;
        m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_brk = 1'b0;
        ev_cyc = -1; busy_lo = -1; busy_hi = -1;
      end
      e_busy = (cyc >= busy_lo) && (cyc < busy_hi);
      chk1("rx_valid", rx_valid, m_valid);
      chk8("rx_data", rx_data, m_data);
      chk1("overrun", overrun, m_ovr);
      chk1("parity_err", parity_err, m_par);
      chk1("frame_err", frame_err, m_frm);
      chk1("break_det", break_det, m_brk);
      chk1("busy", busy, e_busy);
      if (overrun) n_ovr++;
      if (break_det) n_brk++;
      if (frame_err) n_frm++;
      if (rx_valid_e) n_valid_e++;
      if (parity_err_e) n_par_e++;
      if (frame_err_e || break_det_e || overrun_e) n_other_e++;
      m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_brk = 1'b0;
      if (rst_n) begin
        if (ev_cyc == cyc + 1) begin
          case (ev_kind)
            EV_GOOD: begin
              if (m_valid && !rx_ready) m_ovr = 1'b1;
              else begin m_valid = 1'b1; m_data = ev_data; end
            end
            EV_PAR:  m_par = 1'b1;
            EV_FRM:  m_frm = 1'b1;
            default: m_brk = 1'b1;
          endcase
        end
        if (!(ev_cyc == cyc + 1 && ev_kind == EV_GOOD) && m_valid && rx_ready) m_valid = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int nbz;
    logic [7:0] d;
    logic bad;
    repeat (3) step();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_valid", rx_valid, 1'b0);
    rst_n = 1'b1;
    repeat (5) step();

    // 8N1 0xA5, exact latency 154 from t0 (t0 = drive cycle + 2)
    rx_ready = 1'b1;
    n = cyc;
    fork
      send(mk(8'hA5, 1'b1), 10);
      begin
        wait_neg(n + 2 + 153);
        chk1("a5_before", rx_valid, 1'b0);
        wait_neg(n + 2 + 154);
        chk1("a5_valid", rx_valid, 1'b1);
        chk8("a5_data", rx_data, 8'hA5);
        wait_neg(n + 2 + 155);
        chk1("a5_after", rx_valid, 1'b0);
      end
    join
    repeat (6) step();

    // 8E1 0x03 with bad parity bit 1, then a good one with parity 0
    n = cyc;
    fork
      send_e({1'b1, 1'b1, 8'h03, 1'b0});
      begin
        wait_neg(n + 2 + 169);
        chk1("par_e_pre", parity_err_e, 1'b0);
        chk1("busy_e_pre", busy_e, 1'b1);
        wait_neg(n + 2 + 170);
        chk1("par_e_pulse", parity_err_e, 1'b1);
        chk1("busy_e_drop", busy_e, 1'b0);
        wait_neg(n + 2 + 171);
        chk1("par_e_post", parity_err_e, 1'b0);
      end
    join
    repeat (6) step();
    chk1("par_e_no_valid", n_valid_e == 0, 1'b1);
    chk1("par_e_once", n_par_e == 1, 1'b1);
    n = cyc;
    fork
      send_e({1'b1, 1'b0, 8'h03, 1'b0});
      begin
        wait_neg(n + 2 + 170);
        chk1("e_good_valid", rx_valid_e, 1'b1);
        chk8("e_good_data", rx_data_e, 8'h03);
      end
    join
    repeat (6) step();
    chk1("e_no_other_flags", n_other_e == 0, 1'b1);

    // false start: 3 low cycles, then a normal 0x5A frame
    n = cyc;
    busy_lo = n + 3; busy_hi = n + 12; ev_cyc = -1;
    rxd = 1'b0;
    repeat (3) step();
    rxd = 1'b1;
    nbz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) nbz++;
    end
    chk1("false_start_busy_le10", (nbz > 0) && (nbz <= 10), 1'b1);
    step();
    send(mk(8'h5A, 1'b1), 10);
    repeat (6) step();

    // overrun: two frames with no consumer
    rx_ready = 1'b0;
    n_ovr = 0;
    send(mk(8'h11, 1'b1), 10);
    repeat (5) step();
    send(mk(8'h22, 1'b1), 10);
    repeat (5) step();
    chk1("ovr_once", n_ovr == 1, 1'b1);
    chk8("ovr_keep_old", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    chk1("ovr_valid_held", rx_valid, 1'b1);
    @(negedge clk);
    chk1("ovr_valid_cleared", rx_valid, 1'b0);
    step();

    // break: line low for 20 bit times
    n_brk = 0;
    n_frm = 0;
    send(20'd0, 20);
    repeat (6) step();
    chk1("break_once", n_brk == 1, 1'b1);
    chk1("break_no_frame_err", n_frm == 0, 1'b1);

    // reset in the middle of a 0xFF frame, then 0x3C
    n = cyc;
    fork
      send(mk(8'hFF, 1'b1), 10);
      begin
        while (cyc < n + 2 + 60) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_valid", rx_valid, 1'b0);
        chk8("midrst_data", rx_data, 8'h00);
        step();
        step();
        rst_n = 1'b1;
      end
    join
    repeat (6) step();
    send(mk(8'h3C, 1'b1), 10);
    repeat (6) step();

    // randomized frames with a random consumer and occasional bad stop bits
    ready_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send(mk(d, ~bad), 10);
      repeat ($urandom_range(3, 30)) step();
    end
    ready_rand = 1'b0;
    rx_ready = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868, giving clocks per bit; legal values are 8 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal values are 5 to 9.
REQ-003 The block SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits checked; legal values are 1 or 2.
REQ-005 Port CLK, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 Port RST, input, width 1: reset, asynchronous and active-low.
REQ-007 Port uart_rxd, input, width 1: serial line, idle high, asynchronous to CLK.
REQ-008 Port rx_data, output, width DATA_BITS: received word, LSB first on the line.
REQ-009 Port rx_valid, output, width 1: rx_data holds an unread word.
REQ-010 Port rx_ready, input, width 1: consumer accepts the word.
REQ-011 Ports parity_err, frame_err, break_det and overrun, outputs, width 1 each: one-cycle error pulses.
REQ-012 Port busy, output, width 1: high while the FSM is not IDLE.

Function
REQ-013 uart_rxd SHALL pass through a 2-flop synchroniser; all following timing is relative to the synchronised signal (rxs).
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PAR, STOP and WAIT_HIGH.
- PAR is skipped when PARITY = 0.
REQ-015 In IDLE, a 1-to-0 transition on rxs SHALL enter START and clear the bit timer; that cycle is t0.
REQ-016 The bit timer SHALL count 0 to CLK_DIV-1 and then wrap, marking bit boundaries.
- Each bit value is the majority of rxs sampled at counts CLK_DIV/2-1, CLK_DIV/2 and CLK_DIV/2+1.
- The decision is taken at count CLK_DIV/2+1.
REQ-017 START decision: a value of 1 is a false start and returns the FSM to IDLE with no flag; a value of 0 proceeds to DATA.
REQ-018 DATA SHALL shift DATA_BITS decisions LSB first.
REQ-019 PAR SHALL compare the XOR of the data bits with the received parity bit.
- Odd parity requires the total number of ones to be odd.
- Even parity requires it to be even.
REQ-020 STOP SHALL check STOP_BITS decisions, each required to be 1.
- After the last good stop decision the FSM returns to IDLE in the next cycle, without waiting for the end of the bit.
REQ-021 A good frame SHALL load rx_data and assert rx_valid in the cycle after the last stop decision.
- Latency is k*CLK_DIV + CLK_DIV/2 + 2 cycles after t0, where k is the index of the last stop bit and the start bit has index 0.
REQ-022 rx_valid SHALL stay high until a cycle with rx_valid and rx_ready both high, and SHALL clear on the next edge.
REQ-023 When a new good frame completes while rx_valid is high and rx_ready is low, the block SHALL pulse overrun, keep the old rx_data and drop the new word.
REQ-024 When the old word is consumed in the same cycle that a new frame completes, the new word SHALL load, rx_valid SHALL stay high, and no overrun SHALL be signalled.
REQ-025 A parity mismatch SHALL pulse parity_err at the stop-decision cycle + 1, with no data delivered.
REQ-026 A stop bit decoded as 0 with nonzero data or parity SHALL pulse frame_err and enter WAIT_HIGH.
- If all data, parity and stop decisions are 0, the block SHALL pulse break_det instead.
REQ-027 WAIT_HIGH SHALL return to IDLE on the first cycle in which rxs is 1; no start is detected before then.
REQ-028 Only one of parity_err, frame_err, break_det and overrun SHALL pulse per frame.
- Priority, highest first: break_det, frame_err, parity_err, overrun.

Reset
REQ-029 RST low SHALL immediately force the following values, including mid-frame:
- state IDLE
- rx_data 0
- rx_valid 0
- all flags 0
- busy 0
- bit timer 0
- synchroniser flops 1
REQ-030 After RST rises, the first falling edge on rxs SHALL start a new frame, and partial frames SHALL NOT be resumed.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding and the PARITY mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-032 The bit timer with majority sampler SHALL be a sub-module uart_bit_sampler, parametrised by CLK_DIV, with outputs bit_val and bit_strobe.
REQ-033 Illegal parameter values SHALL be rejected at elaboration.

Verification
All scenarios use CLK_DIV=16.
REQ-034 8N1, send 0xA5 with rx_ready=1 -> rx_data=0xA5 and rx_valid high exactly 154 cycles after t0 for one cycle; no flags.
REQ-035 8E1, send 0x03 with parity bit 1 -> parity_err pulse at t0+170; rx_valid stays 0; busy drops at t0+170.
REQ-036 rxd low for 3 cycles, then high -> false start; busy high for at most 10 cycles; no flags; the next frame 0x5A is received correctly.
REQ-037 8N1, rx_ready=0, send 0x11 then 0x22 -> after frame 2, overrun pulses once and rx_data=0x11; then rx_ready=1 -> rx_valid clears on the next edge.
REQ-038 rxd held low for 20 bit times -> break_det pulses exactly once; no frame_err; busy stays high until rxd returns high.
REQ-039 RST low at t0+60 for 2 cycles during frame 0xFF -> all outputs 0 and busy 0; no rx_valid for the remnant; a following frame 0x3C is received correctly.
